// File: rtl/rv_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_REQ ready/valid senders share one downstream
// ready/valid channel. The winner is forwarded in the same cycle it is chosen. Once a
// beat is offered, the grant is held until the beat flagged last is accepted.
module rv_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] rr_ptr_q;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid;
  logic                  sel_active;
  logic                  sel_last;
  logic                  hs;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Modulo-NUM_REQ increment; also handles non-power-of-2 requester counts.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pick the forwarded requester: the locked owner, else the IDLE winner.
  always_comb begin
    if (state_q == StLocked) begin
      sel_idx    = gnt_q;
      sel_valid  = in_valid[gnt_q];
      sel_active = 1'b1;
    end else if (win_found) begin
      sel_idx    = win_idx;
      sel_valid  = 1'b1;
      sel_active = 1'b1;
    end else begin
      sel_idx    = gnt_q;
      sel_valid  = 1'b0;
      sel_active = 1'b0;
    end
  end

  // Forwarding path; reset gates every handshake combinationally.
  always_comb begin
    in_ready  = '0;
    out_valid = sel_valid & ~reset;
    out_data  = data_arr[sel_idx];
    out_last  = in_last[sel_idx];
    sel_last  = in_last[sel_idx];
    grant_idx = sel_idx;
    busy      = (state_q == StLocked) & ~reset;
    if (sel_active && !reset) begin
      // A locked owner sees out_ready even during a bubble; no beat moves without valid.
      in_ready[sel_idx] = out_ready;
    end
    hs = out_valid & out_ready;
  end

  // Grant lock and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            if (hs && sel_last) begin
              rr_ptr_q <= wrap_inc(win_idx);
            end else begin
              // Either a multi-beat packet started or the beat is stalled: hold it.
              state_q <= StLocked;
              gnt_q   <= win_idx;
            end
          end
        end
        StLocked: begin
          if (hs && sel_last) begin
            state_q  <= StIdle;
            rr_ptr_q <= wrap_inc(gnt_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Bench for rv_rr_arbiter: directed reset/rotation/backpressure checks followed by
// randomized ready/valid traffic compared against a behavioural model.
module tb_rv_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [IW-1:0]   grant_idx;
  logic            busy;
  logic [DW-1:0]   d [N];

  int total = 0;
  int bad   = 0;

  // Model state: whether a packet owns the channel, who owns it, who goes first next.
  bit m_locked;
  int m_owner;
  int m_ptr;
  bit m_hs;
  int m_sel;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign in_data[i*DW +: DW] = d[i];
  end

  rv_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .grant_idx(grant_idx),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs against the model at the falling edge, then advance
  // the model to what the rising edge should commit. Returns at posedge + 1.
  task automatic tick();
    bit           ev;
    int           sel;
    int           c;
    logic [N-1:0] erdy;
    bit           lb;
    @(negedge clk);
    sel = m_owner;
    ev  = 1'b0;
    if (m_locked) begin
      ev = in_valid[m_owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!ev && in_valid[c]) begin
          ev  = 1'b1;
          sel = c;
        end
      end
    end
    erdy = '0;
    if (!reset && (m_locked || ev)) erdy[sel] = out_ready;
    chk("out_valid", 32'(out_valid), 32'(ev && !reset));
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk("busy", 32'(busy), 32'(m_locked && !reset));
    if (!reset) chk("grant_idx", 32'(grant_idx), 32'(sel));
    if (!reset && ev) begin
      chk("out_data", 32'(out_data), 32'(d[sel]));
      chk("out_last", 32'(out_last), 32'(in_last[sel]));
    end
    lb    = in_last[sel];
    m_hs  = !reset && ev && out_ready;
    m_sel = sel;
    if (reset) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
    end else if (!m_locked) begin
      if (ev) begin
        if (m_hs && lb) begin
          m_ptr = (sel + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = sel;
        end
      end
    end else if (m_hs && lb) begin
      m_locked = 1'b0;
      m_ptr    = (m_owner + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 8'(i * 17);
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_hs     = 1'b0;
    m_sel    = 0;
    @(posedge clk);
    #1;

    // Reset hold: everything requesting, nothing may be accepted.
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      tick();
    end
    reset = 1'b0;

    // Rotation with single-beat packets, starting at 0 right after reset.
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("rot_grant", 32'(grant_idx), 32'(k % N));
      chk("rot_ready", 32'(in_ready), 32'(1 << (k % N)));
      tick();
    end

    // Backpressure: a stalled offer from req2 must not be stolen by req0.
    in_valid  = 4'b0100;
    d[2]      = 8'hA5;
    out_ready = 1'b0;
    tick();
    in_valid[0] = 1'b1;
    d[0]        = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_grant", 32'(grant_idx), 32'(2));
      chk("bp_data", 32'(out_data), 32'(8'hA5));
      chk("bp_valid", 32'(out_valid), 32'(1));
      tick();
    end
    out_ready = 1'b1;
    #2;
    chk("bp_release", 32'(in_ready), 32'(4'b0100));
    tick();
    in_valid[2] = 1'b0;
    #2;
    chk("bp_next", 32'(grant_idx), 32'(0));
    tick();

    // Random ready/valid traffic; senders hold an offered beat until it is accepted.
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && !(m_hs && m_sel == i))) begin
          in_valid[i] = 1'($urandom_range(0, 1));
          d[i]        = 8'($urandom);
          in_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_rr_arbiter.md
Name: rv_rr_arbiter

Overview:
- N-to-1 round-robin arbiter sharing one downstream ready/valid channel among NUM_REQ upstream ready/valid senders.
- Packet-aware: a grant is held from the first beat through the beat flagged `last`, so packets never interleave.
- Sits in front of a shared FIFO or consumer in the rtl_libraries FIFO family.
- Zero-latency forwarding path; sequential state is the grant lock and the round-robin pointer.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- DATA_WIDTH, 8, payload width per beat.
- IDX_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), grant index width (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_REQ  per-requester valid.
- in_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  NUM_REQ  per-requester end-of-packet flag.
- in_ready  output  NUM_REQ  per-requester ready.
- out_valid  output  1  downstream valid.
- out_data  output  DATA_WIDTH  downstream data.
- out_last  output  1  downstream end-of-packet.
- out_ready  input  1  downstream ready.
- grant_idx  output  IDX_W  index of the currently forwarded requester.
- busy  output  1  high while a grant is locked.

Behaviour:
- Registers:
  - state {IDLE, LOCKED}
  - gnt (IDX_W)
  - rr_ptr (IDX_W)
- Reset (reset=1 at a clock edge):
  - state=IDLE, gnt=0, rr_ptr=0.
  - While reset is high: out_valid=0, in_ready all 0, busy=0. Combinational gating; no handshake can complete during reset.
- A handshake on requester i is in_valid[i] & in_ready[i]. This is equivalent to out_valid & out_ready with grant_idx=i.
- IDLE:
  - winner = first i with in_valid[i]=1, searched in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - If no valid: out_valid=0, in_ready=0, grant_idx=gnt.
  - Else forward the winner in the same cycle (0-cycle latency): out_valid=1, out_data/out_last=winner's, in_ready[winner]=out_ready, other in_ready=0, grant_idx=winner.
- IDLE transitions:
  - Handshake with out_last=1: stay IDLE; rr_ptr<=winner+1 mod NUM_REQ.
  - Handshake with out_last=0: LOCKED, gnt<=winner.
  - out_valid=1 & out_ready=0: LOCKED, gnt<=winner. The offered beat must stay stable; later higher-priority requests must not steal it.
- LOCKED:
  - Forward only gnt: out_valid=in_valid[gnt], out_data/out_last=gnt's, in_ready[gnt]=out_ready, others 0, grant_idx=gnt, busy=1.
  - Handshake with out_last=1: IDLE, rr_ptr<=gnt+1 mod NUM_REQ.
  - Otherwise stay LOCKED. Bubbles (in_valid[gnt]=0) mid-packet keep the grant.
- Fairness: after a packet completes, the finishing requester has lowest priority. With all requesters continuously valid with 1-beat packets, grants rotate 0,1,2,3,0...
- Wrap-around: rr_ptr increments mod NUM_REQ. For non-power-of-2 NUM_REQ, value NUM_REQ-1 wraps to 0.
- NUM_REQ=1: degenerates to pass-through with lock bookkeeping; rr_ptr stays 0.
- Reset mid-packet: the packet is abandoned; the next cycle is IDLE, rr_ptr=0. Upstream is responsible for recovery.
- out_valid never depends on out_ready (no combinational ready->valid path).
- in_ready[i] depends combinationally on out_ready and in_valid (via the IDLE arbitration).

Test Plan:
- Reset hold: reset=1 for 3 cycles with all in_valid=1, out_ready=1 -> out_valid=0, in_ready=0000 throughout; first cycle after reset, grant_idx=0.
- Rotation: NUM_REQ=4, all in_valid=1, in_last=1, out_ready=1 for 8 cycles -> grant_idx sequence 0,1,2,3,0,1,2,3; exactly one in_ready bit set each cycle.
- Packet lock: req1 sends a 3-beat packet (last on beat 3) while req0 and req2 are valid, out_ready=1 -> 3 consecutive beats from req1 with busy=1 on beats 2-3; the next grant is 2, not 0.
- Backpressure stability:
  - Stimulus: req2 valid with data 0xA5, out_ready=0 for 4 cycles; req0 asserts valid at cycle 2.
  - Response: out_data stays 0xA5, grant_idx stays 2, out_valid stays 1.
  - When out_ready=1, the handshake completes on req2 and req0 is granted the next cycle.
- Mid-packet bubble: req3 beat 1 (last=0) accepted, then in_valid[3]=0 for 2 cycles while req1 valid -> out_valid=0 and in_ready[1]=0 during the bubble; req3 beat 2 (last=1) then completes and rr_ptr=0.
- Reset mid-packet: reset pulsed while LOCKED on req2 -> next cycle busy=0, IDLE; with req1 and req3 valid, grant_idx=1.
